// File: rtl/hci_package.sv
// Shared types and elaboration-time helpers for the prioritised HCI log interconnect.
//   hci_log_prio_ctrl_t : runtime arbitration controls that are fanned out to every bank
//   hci_boff()          : byte-offset width of a data word (address bits below the bank index)
//   hci_bank_sel_w()    : number of address bits that select a bank
//   hci_idx_w()         : index width for n items, never less than 1
package hci_package;

   typedef struct packed {
      logic       invert_prio;  // 1: class 1 becomes the high-priority class
      logic [7:0] max_stall;    // low-class stall limit, 0 = strict priority
   } hci_log_prio_ctrl_t;

   function automatic int unsigned hci_boff(input int unsigned dw);
      return $clog2(dw / 8);
   endfunction

   function automatic int unsigned hci_bank_sel_w(input int unsigned n_mem);
      return $clog2(n_mem);
   endfunction

   function automatic int unsigned hci_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hci_log_bank_arbiter.sv
// Per-bank two-class arbiter with a low-class starvation guard and response ID pipeline.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   ctrl_i           priority inversion and stall limit
//   req_i[NC]        channels currently targeting this bank (class 0 = low indices)
//   mem_gnt_i        bank accepts the presented request this cycle
//   winner_o[NC]     one-hot arbitration winner (zero when no request)
//   resp_valid_o     a response for this bank is due this cycle
//   resp_idx_o       channel index that owns the due response
module hci_log_bank_arbiter
   import hci_package::*;
#(
   parameter int unsigned N_CH0    = 8,
   parameter int unsigned N_CH1    = 4,
   parameter int unsigned RESP_LAT = 1,
   localparam int unsigned NC      = N_CH0 + N_CH1,
   localparam int unsigned IW      = hci_idx_w(NC)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  hci_log_prio_ctrl_t ctrl_i,
   input  logic [NC-1:0]      req_i,
   input  logic               mem_gnt_i,
   output logic [NC-1:0]      winner_o,
   output logic               resp_valid_o,
   output logic [IW-1:0]      resp_idx_o
);

   localparam int unsigned PW0 = hci_idx_w(N_CH0);
   localparam int unsigned PW1 = hci_idx_w(N_CH1);

   logic [PW0-1:0] ptr0_q, ptr0_d, sel0;
   logic [PW1-1:0] ptr1_q, ptr1_d, sel1;
   logic [7:0]     stall_cnt_q, stall_cnt_d;
   logic           forced_q, forced_d;
   logic [RESP_LAT-1:0]         rv_q;
   logic [RESP_LAT-1:0][IW-1:0] rid_q;

   logic [N_CH0-1:0] req0;
   logic [N_CH1-1:0] req1;
   logic hi_is_1, hi_req, lo_req, serve_low, cls1_wins, any_req, xfer, lose;
   logic found0, found1;
   logic [IW-1:0] win_idx;
   int unsigned idx0, idx1;

   assign req0 = req_i[N_CH0-1:0];
   assign req1 = req_i[NC-1:N_CH0];

   // Round-robin search: first requester at or after the class pointer, wrapping.
   always_comb begin
      sel0   = ptr0_q;
      found0 = 1'b0;
      idx0   = 0;
      for (int unsigned k = 0; k < N_CH0; k++) begin
         idx0 = 32'(ptr0_q) + k;
         if (idx0 >= N_CH0) idx0 = idx0 - N_CH0;
         if (!found0 && req0[PW0'(idx0)]) begin
            found0 = 1'b1;
            sel0   = PW0'(idx0);
         end
      end
   end

   always_comb begin
      sel1   = ptr1_q;
      found1 = 1'b0;
      idx1   = 0;
      for (int unsigned k = 0; k < N_CH1; k++) begin
         idx1 = 32'(ptr1_q) + k;
         if (idx1 >= N_CH1) idx1 = idx1 - N_CH1;
         if (!found1 && req1[PW1'(idx1)]) begin
            found1 = 1'b1;
            sel1   = PW1'(idx1);
         end
      end
   end

   assign hi_is_1   = ctrl_i.invert_prio;
   assign hi_req    = hi_is_1 ? (|req1) : (|req0);
   assign lo_req    = hi_is_1 ? (|req0) : (|req1);
   assign serve_low = lo_req && (!hi_req || forced_q);
   // Class 1 wins when it is the high class and the low class is not served, or vice versa.
   assign cls1_wins = hi_is_1 ^ serve_low;
   assign any_req   = |req_i;
   assign xfer      = any_req && mem_gnt_i;
   assign lose      = lo_req && !serve_low;
   assign win_idx   = cls1_wins ? (IW'(N_CH0) + IW'(sel1)) : IW'(sel0);

   always_comb begin
      winner_o = '0;
      if (any_req) winner_o[win_idx] = 1'b1;
   end

   // Pointers only advance on an accepted transfer of their own class.
   always_comb begin
      ptr0_d = ptr0_q;
      ptr1_d = ptr1_q;
      if (xfer && !cls1_wins) ptr0_d = (32'(sel0) == N_CH0 - 1) ? '0 : sel0 + 1'b1;
      if (xfer &&  cls1_wins) ptr1_d = (32'(sel1) == N_CH1 - 1) ? '0 : sel1 + 1'b1;
   end

   // Starvation guard: the compare uses the live limit, so lowering it mid-count
   // (counter already above the limit) also forces the low class.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      forced_d    = forced_q;
      if (ctrl_i.max_stall == 8'd0) begin
         stall_cnt_d = '0;
         forced_d    = 1'b0;
      end else if (xfer && serve_low) begin
         stall_cnt_d = '0;
         forced_d    = 1'b0;
      end else begin
         if (lose && stall_cnt_q != 8'hFF) stall_cnt_d = stall_cnt_q + 8'd1;
         if (stall_cnt_q >= ctrl_i.max_stall) forced_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr0_q      <= '0;
         ptr1_q      <= '0;
         stall_cnt_q <= '0;
         forced_q    <= 1'b0;
         rv_q        <= '0;
         rid_q       <= '0;
      end else begin
         ptr0_q      <= ptr0_d;
         ptr1_q      <= ptr1_d;
         stall_cnt_q <= stall_cnt_d;
         forced_q    <= forced_d;
         rv_q[0]     <= xfer;
         rid_q[0]    <= win_idx;
         for (int s = 1; s < RESP_LAT; s++) begin
            rv_q[s]  <= rv_q[s-1];
            rid_q[s] <= rid_q[s-1];
         end
      end
   end

   assign resp_valid_o = rv_q[RESP_LAT-1];
   assign resp_idx_o   = rid_q[RESP_LAT-1];

endmodule

// File: rtl/hci_log_interconnect_prio.sv
// Word-interleaved logarithmic crossbar from N_CH0+N_CH1 HCI channels to N_MEM TCDM banks
// with two-class priority arbitration per bank.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   ctrl_invert_prio_i            1: class 1 (channels N_CH0..NC-1) is high priority
//   ctrl_max_stall_i              low-class stall limit, 0 = strict priority
//   core_*                        channel request side (req/add/we_n/be/wdata, gnt/r_valid/r_rdata)
//   mem_*                         bank side (req/add/we_n/be/wdata, gnt/r_rdata)
//   perf_conflicts_o              saturating count of conflicting banks per cycle
// Build option: HCI_LOG_PERF_CNT_EN enables the conflict counter; otherwise it reads 0.
module hci_log_interconnect_prio
   import hci_package::*;
#(
   parameter int unsigned N_CH0    = 8,
   parameter int unsigned N_CH1    = 4,
   parameter int unsigned N_MEM    = 16,
   parameter int unsigned AWC      = 32,
   parameter int unsigned AWM      = 12,
   parameter int unsigned DW       = 32,
   parameter int unsigned BW       = 8,
   parameter int unsigned UW       = 0,
   parameter int unsigned RESP_LAT = 1,
   localparam int unsigned NC      = N_CH0 + N_CH1,
   localparam int unsigned DWU     = DW + UW,
   localparam int unsigned BEW     = DW / BW
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 ctrl_invert_prio_i,
   input  logic [7:0]           ctrl_max_stall_i,
   input  logic [NC-1:0]        core_req_i,
   input  logic [NC*AWC-1:0]    core_add_i,
   input  logic [NC-1:0]        core_we_n_i,
   input  logic [NC*BEW-1:0]    core_be_i,
   input  logic [NC*DWU-1:0]    core_wdata_i,
   output logic [NC-1:0]        core_gnt_o,
   output logic [NC-1:0]        core_r_valid_o,
   output logic [NC*DWU-1:0]    core_r_rdata_o,
   output logic [N_MEM-1:0]     mem_req_o,
   output logic [N_MEM*AWM-1:0] mem_add_o,
   output logic [N_MEM-1:0]     mem_we_n_o,
   output logic [N_MEM*BEW-1:0] mem_be_o,
   output logic [N_MEM*DWU-1:0] mem_wdata_o,
   input  logic [N_MEM-1:0]     mem_gnt_i,
   input  logic [N_MEM*DWU-1:0] mem_r_rdata_i,
   output logic [31:0]          perf_conflicts_o
);

   localparam int unsigned BOFF = hci_boff(DW);
   localparam int unsigned BSW  = hci_bank_sel_w(N_MEM);
   localparam int unsigned IW   = hci_idx_w(NC);

   hci_log_prio_ctrl_t ctrl;
   assign ctrl.invert_prio = ctrl_invert_prio_i;
   assign ctrl.max_stall   = ctrl_max_stall_i;

   logic [NC-1:0][BSW-1:0]    ch_bank;
   logic [NC-1:0][AWM-1:0]    ch_word;
   logic [N_MEM-1:0][NC-1:0]  bank_req, bank_win;
   logic [N_MEM-1:0]          resp_valid;
   logic [N_MEM-1:0][IW-1:0]  resp_idx;

   // Address decode: bank index sits just above the byte offset, word address above that.
   for (genvar gi = 0; gi < NC; gi++) begin : g_dec
      assign ch_bank[gi] = core_add_i[gi*AWC+BOFF +: BSW];
      assign ch_word[gi] = core_add_i[gi*AWC+BOFF+BSW +: AWM];
   end

   for (genvar gb = 0; gb < N_MEM; gb++) begin : g_bank
      logic [AWM-1:0] add_m;
      logic           we_m;
      logic [BEW-1:0] be_m;
      logic [DWU-1:0] wd_m;

      for (genvar gc = 0; gc < NC; gc++) begin : g_req
         assign bank_req[gb][gc] = core_req_i[gc] && (ch_bank[gc] == BSW'(gb));
      end

      hci_log_bank_arbiter #(
         .N_CH0    (N_CH0),
         .N_CH1    (N_CH1),
         .RESP_LAT (RESP_LAT)
      ) i_arb (
         .clk_i        (clk_i),
         .rst_ni       (rst_ni),
         .ctrl_i       (ctrl),
         .req_i        (bank_req[gb]),
         .mem_gnt_i    (mem_gnt_i[gb]),
         .winner_o     (bank_win[gb]),
         .resp_valid_o (resp_valid[gb]),
         .resp_idx_o   (resp_idx[gb])
      );

      // Winner is one-hot, so a priority-free select is sufficient.
      always_comb begin
         add_m = '0;
         we_m  = 1'b1;
         be_m  = '0;
         wd_m  = '0;
         for (int c = 0; c < NC; c++) begin
            if (bank_win[gb][c]) begin
               add_m = ch_word[c];
               we_m  = core_we_n_i[c];
               be_m  = core_be_i[c*BEW +: BEW];
               wd_m  = core_wdata_i[c*DWU +: DWU];
            end
         end
      end

      assign mem_req_o[gb]                 = |bank_req[gb];
      assign mem_add_o[gb*AWM +: AWM]      = add_m;
      assign mem_we_n_o[gb]                = we_m;
      assign mem_be_o[gb*BEW +: BEW]       = be_m;
      assign mem_wdata_o[gb*DWU +: DWU]    = wd_m;
   end

   // A channel targets one bank per cycle, so at most one bank grants or responds to it.
   always_comb begin
      core_gnt_o     = '0;
      core_r_valid_o = '0;
      core_r_rdata_o = '0;
      for (int c = 0; c < NC; c++) begin
         for (int b = 0; b < N_MEM; b++) begin
            if (bank_win[b][c] && mem_gnt_i[b]) core_gnt_o[c] = 1'b1;
            if (resp_valid[b] && (resp_idx[b] == IW'(c))) begin
               core_r_valid_o[c]              = 1'b1;
               core_r_rdata_o[c*DWU +: DWU]   = mem_r_rdata_i[b*DWU +: DWU];
            end
         end
      end
   end

`ifdef HCI_LOG_PERF_CNT_EN
   logic [31:0] perf_q, perf_d;
   logic [32:0] perf_sum;

   always_comb begin
      perf_sum = {1'b0, perf_q};
      for (int b = 0; b < N_MEM; b++) begin
         if ($countones(bank_req[b]) >= 2) perf_sum = perf_sum + 33'd1;
      end
      perf_d = perf_sum[32] ? 32'hFFFF_FFFF : perf_sum[31:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) perf_q <= '0;
      else         perf_q <= perf_d;
   end

   assign perf_conflicts_o = perf_q;
`else
   assign perf_conflicts_o = '0;
`endif

endmodule

// File: doc/hci_log_interconnect_prio.md
Name: hci_log_interconnect_prio

Overview:
Parametrised word-interleaved logarithmic crossbar. It connects N_CH0+N_CH1 HCI core channels to N_MEM single-ported TCDM banks.
- Successor to the plain LIC wrapper: two-class priority arbitration per bank, runtime priority inversion, a starvation guard for the low-priority class, and configurable response latency.
- Sits between cluster cores/accelerator ports and the TCDM banks.

Parameters:
N_CH0, 8, channels in class 0 (default high priority)
N_CH1, 4, channels in class 1 (default low priority)
N_MEM, 16, number of banks; power of two, >=2
AWC, 32, core address width
AWM, 12, bank word-address width
DW, 32, data width
BW, 8, bits per byte-enable
UW, 0, user bits appended to data (0 = none)
RESP_LAT, 1, bank read latency in cycles (1 or 2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ctrl_invert_prio_i  in  1  1: class 1 is high priority
ctrl_max_stall_i  in  8  low-class stall limit; 0 = strict priority
core_req_i  in  NC  request per channel (NC = N_CH0+N_CH1)
core_add_i  in  NC*AWC  byte address
core_we_n_i  in  NC  0 = write
core_be_i  in  NC*DW/BW  byte enables
core_wdata_i  in  NC*(DW+UW)  write data + user
core_gnt_o  out  NC  grant
core_r_valid_o  out  NC  response valid (reads and writes)
core_r_rdata_o  out  NC*(DW+UW)  read data + user
mem_req_o  out  N_MEM  bank request
mem_add_o  out  N_MEM*AWM  bank word address
mem_we_n_o  out  N_MEM  0 = write
mem_be_o  out  N_MEM*DW/BW  byte enables
mem_wdata_o  out  N_MEM*(DW+UW)  write data
mem_gnt_i  in  N_MEM  bank accepts request
mem_r_rdata_i  in  N_MEM*(DW+UW)  bank read data, valid RESP_LAT cycles after accept
perf_conflicts_o  out  32  conflict counter (see Optional Feature)

Behaviour:
- One clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Address decode:
  - BOFF = $clog2(DW/8).
  - Bank = add[BOFF +: log2(N_MEM)].
  - mem_add = add[BOFF+log2(N_MEM) +: AWM]; upper bits ignored.
- Per-bank arbitration (combinational):
  - High class = class 0, or class 1 when ctrl_invert_prio_i=1.
  - Round-robin within each class; each class has its own pointer.
  - Serve the low class when no high-class request targets the bank, or when the forced flag is set (see stall counter).
- Grant: core_gnt_o[i] = winner(i) && mem_gnt_i[bank]; same cycle, zero latency. A losing channel keeps its request stable until granted.
- Pointer update: on a granted transfer only, the winning class pointer moves to winner+1, wrapping modulo class size. No grant leaves the pointer unchanged.
- Stall counter (8 bit per bank):
  - Increments each cycle a low-class request to the bank loses to the high class.
  - When counter == ctrl_max_stall_i != 0, the forced flag sets and the low class wins the next arbitration.
  - Counter and forced flag clear on any granted low-class transfer.
  - ctrl_max_stall_i=0: never forced, counter held at 0.
  - ctrl_max_stall_i changed mid-count: compare is against the live value; counter > limit also forces.
- Response path:
  - Per bank, a RESP_LAT-deep shift register of {valid, channel index}, loaded on a granted transfer.
  - core_r_valid_o asserts exactly RESP_LAT cycles after grant, for reads and writes.
  - core_r_rdata_o is muxed from that bank. Channels with no response see rdata 0.
  - A channel has at most one grant per cycle, so responses never collide.
- Back-to-back grants every cycle are supported, with no bubbles.
- Reset values:
  - Pointers, counters, forced flags and response pipeline all 0.
  - core_r_valid_o = 0 and perf_conflicts_o = 0.
  - Combinational outputs follow inputs.
- Reset mid-operation drops in-flight responses; no r_valid is produced for them.
- mem_req_o is low when no request targets the bank. mem_wdata, mem_be and mem_add are don't-care when mem_req_o is low.

Optional Feature:
HCI_LOG_PERF_CNT_EN
- Defined: perf_conflicts_o is a 32-bit saturating counter, incremented once per cycle per bank that has >=2 simultaneous requests (+k for k conflicting banks in that cycle). It clears only on reset.
- Undefined: perf_conflicts_o is tied to 0 and no counter logic exists.

Decomposition:
- Shared package (hci_package): hci_log_prio_ctrl_t {invert_prio, max_stall[7:0]} and localparam helpers for BOFF and bank-select width.
- Sub-module hci_log_bank_arbiter, one instance per bank. It owns both round-robin pointers, the stall counter, the forced flag, the winner one-hot and the response ID shift register.

Test Plan:
- Ch0 and ch9 write the same bank 0, max_stall=0, no inversion -> ch0 granted first; ch9 waits every cycle while class-0 requests persist.
- Ch1 and ch2 hold requests to bank 3 continuously, max_stall=0, no inversion -> grants alternate ch1, ch2, ch1, ...; each r_valid arrives 1 cycle after grant (RESP_LAT=1).
- Ch0 streams to bank 5; ch8 requests bank 5; max_stall=3 -> ch8 granted on the 5th cycle, after 4 stall cycles (count reaches 3, then forced); counter returns to 0.
- ctrl_invert_prio_i=1, ch0 and ch8 to the same bank -> ch8 granted first.
- RESP_LAT=2, ch4 reads address 0x44 (bank 1, word 1, N_MEM=16) while the bank returns 0xDEADBEEF -> mem_add=0x1; core_r_valid_o[4] high 2 cycles after grant with 0xDEADBEEF.
- rst_ni pulsed low one cycle after a grant -> no r_valid; perf_conflicts_o = 0 after release.
